// File: rtl/toggle_cover_collector.sv
// Per-bit toggle coverage: saturating rise/fall counters, a sticky covered mask and a
// serial valid/ready dump of the counts (counts freeze while a dump is in progress).
module toggle_cover_collector #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 8,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 10906,
  parameter int IDX_W       = $clog2(WIDTH > 1 ? WIDTH : 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sig,
  input  logic             clear,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] out_rise_cnt,
  output logic [CNT_W-1:0] out_fall_cnt,
  output logic             busy,
  output logic [WIDTH-1:0] covered_mask,
  output logic             all_covered
);

  typedef enum logic {
    S_IDLE,
    S_DUMP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  if (WIDTH < 1 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_param_check
    $error("toggle_cover_collector: bad WIDTH or cover index range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_ok_q;
  logic [CNT_W-1:0] rise_cnt_q [WIDTH];
  logic [CNT_W-1:0] rise_cnt_d [WIDTH];
  logic [CNT_W-1:0] fall_cnt_q [WIDTH];
  logic [CNT_W-1:0] fall_cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             all_q;
  logic [WIDTH-1:0] rise, fall;
  logic             count_en;

  assign rise     = {WIDTH{prev_ok_q & enable}} & ~prev_q & sig;
  assign fall     = {WIDTH{prev_ok_q & enable}} & prev_q & ~sig;
  assign count_en = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // clear aborts any dump and beats a same-cycle dump_req
    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
  end

  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    mask_d     = mask_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (clear) begin
        rise_cnt_d[i] = '0;
        fall_cnt_d[i] = '0;
        mask_d[i]     = 1'b0;
      end else begin
        if (count_en && rise[i] && rise_cnt_q[i] != CNT_MAX) begin
          rise_cnt_d[i] = rise_cnt_q[i] + CNT_W'(1);
        end
        if (count_en && fall[i] && fall_cnt_q[i] != CNT_MAX) begin
          fall_cnt_d[i] = fall_cnt_q[i] + CNT_W'(1);
        end
        mask_d[i] = mask_q[i] | ((rise_cnt_d[i] != '0) & (fall_cnt_d[i] != '0));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      rise_cnt_q <= '{default: '0};
      fall_cnt_q <= '{default: '0};
      mask_q     <= '0;
      all_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      // prev keeps tracking sig during a dump so no stale edge appears afterwards
      if (enable) begin
        prev_q <= sig;
      end
      prev_ok_q  <= enable;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      mask_q     <= mask_d;
      all_q      <= &mask_d;
    end
  end

  assign out_valid    = (state_q == S_DUMP);
  assign busy         = (state_q == S_DUMP);
  assign out_index    = idx_q;
  assign out_rise_cnt = rise_cnt_q[idx_q];
  assign out_fall_cnt = fall_cnt_q[idx_q];
  assign covered_mask = mask_q;
  assign all_covered  = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=4, CNT_W=2 so saturation is reachable).
`define CHK(tag, obs, exp) \
    begin \
        n_assert++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_toggle_cover_collector;

    logic       clock = 1'b0;
    logic       reset, enable, clear, dump_req, out_ready;
    logic [3:0] sig;
    logic       out_valid, busy, all_covered;
    logic [1:0] out_index, out_rise_cnt, out_fall_cnt;
    logic [3:0] covered_mask;

    int n_assert = 0;
    int n_fail   = 0;

    toggle_cover_collector #(
        .WIDTH(4), .CNT_W(2), .COVER_INDEX(0), .COVER_TOTAL(10906)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .sig(sig),
        .clear(clear), .dump_req(dump_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_rise_cnt(out_rise_cnt), .out_fall_cnt(out_fall_cnt),
        .busy(busy), .covered_mask(covered_mask), .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        n_assert++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 2'd0 ||
            covered_mask !== 4'h0 || all_covered !== 1'b0) begin
            n_fail++;
            $error("FAIL %s: reset state valid=%0b busy=%0b idx=%0d mask=%0h all=%0b",
                   tag, out_valid, busy, out_index, covered_mask, all_covered);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int cnt;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < max_cycles) begin
            tick();
            cnt++;
        end
        n_assert++;
        if (cnt >= max_cycles) begin
            n_fail++;
            $error("FAIL %s: out_valid not seen within %0d cycles", tag, max_cycles);
        end
    endtask

    // Dump all four records; each record is stalled for `stall` cycles before its handshake.
    // If flip2 is set, sig[2] is changed during the dump (must not be counted, now or later).
    task automatic dump_check(input logic [3:0][1:0] er, input logic [3:0][1:0] ef,
                              input int stall, input bit flip2);
        logic [1:0] ei;
        dump_req  = 1'b1;
        out_ready = 1'b0;
        tick();
        dump_req = 1'b0;
        `CHK("dump_busy", busy, 1'b1)
        for (int i = 0; i < 4; i++) begin
            ei = 2'(i);
            for (int s = 0; s < stall; s++) begin
                if (flip2 && i == 0 && s == 0) sig[2] = ~sig[2];
                `CHK("stall_valid", out_valid, 1'b1)
                `CHK("stall_index", out_index, ei)
                `CHK("stall_rise", out_rise_cnt, er[i])
                `CHK("stall_fall", out_fall_cnt, ef[i])
                tick();
            end
            out_ready = 1'b1;
            `CHK("rec_valid", out_valid, 1'b1)
            `CHK("rec_index", out_index, ei)
            `CHK("rec_rise", out_rise_cnt, er[i])
            `CHK("rec_fall", out_fall_cnt, ef[i])
            tick();
            out_ready = 1'b0;
        end
        `CHK("dump_end_valid", out_valid, 1'b0)
        `CHK("dump_end_busy", busy, 1'b0)
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; dump_req = 1'b0; out_ready = 1'b0; sig = 4'h0;
        tick(); tick();
        check_reset_state("rst_state");
        `CHK("rst_valid", out_valid, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_index", out_index, 2'd0)
        `CHK("rst_mask", covered_mask, 4'h0)
        `CHK("rst_all", all_covered, 1'b0)
        reset = 1'b0;

        // T1: 0000 -> 0101 -> 0000
        enable = 1'b1; sig = 4'h0; tick();
        sig = 4'b0101; tick();
        `CHK("t1_mask_rise_only", covered_mask, 4'h0)
        sig = 4'b0000; tick();
        `CHK("t1_mask", covered_mask, 4'b0101)
        `CHK("t1_all", all_covered, 1'b0)
        dump_check({2'd0, 2'd1, 2'd0, 2'd1}, {2'd0, 2'd1, 2'd0, 2'd1}, 0, 1'b0);
        do_clear();
        `CHK("t1_clear_mask", covered_mask, 4'h0)

        // T2: toggle bit0 ten times with 2-bit counters -> both saturate at 3
        for (int k = 0; k < 10; k++) begin
            sig[0] = ~sig[0];
            tick();
        end
        `CHK("t2_mask", covered_mask, 4'b0001)
        dump_check({2'd0, 2'd0, 2'd0, 2'd3}, {2'd0, 2'd0, 2'd0, 2'd3}, 0, 1'b0);
        do_clear();

        // T3: rise=[2,1,0,3], fall=[2,0,0,2]; stalled dump, sig[2] changes mid-dump
        sig = 4'b1011; tick();
        sig = 4'b0010; tick();
        sig = 4'b1011; tick();
        sig = 4'b0010; tick();
        sig = 4'b1010; tick();
        `CHK("t3_mask", covered_mask, 4'b1001)
        dump_check({2'd3, 2'd0, 2'd1, 2'd2}, {2'd2, 2'd0, 2'd0, 2'd2}, 3, 1'b1);
        tick();
        dump_check({2'd3, 2'd0, 2'd1, 2'd2}, {2'd2, 2'd0, 2'd0, 2'd2}, 0, 1'b0);
        `CHK("t3_mask_after", covered_mask, 4'b1001)
        do_clear();

        // T4: reach full coverage, then clear mid-dump at idx1
        sig = 4'b0000; tick();
        sig = 4'b1111; tick();
        `CHK("t4_mask_partial", covered_mask, 4'b1110)
        `CHK("t4_all_partial", all_covered, 1'b0)
        sig = 4'b0000; tick();
        `CHK("t4_mask_full", covered_mask, 4'b1111)
        `CHK("t4_all_full", all_covered, 1'b1)
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        wait_valid("t4_dump_start", 4);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        `CHK("t4_at_idx1", out_index, 2'd1)
        clear = 1'b1; tick(); clear = 1'b0;
        `CHK("t4_clr_valid", out_valid, 1'b0)
        `CHK("t4_clr_busy", busy, 1'b0)
        `CHK("t4_clr_index", out_index, 2'd0)
        `CHK("t4_clr_mask", covered_mask, 4'h0)
        `CHK("t4_clr_all", all_covered, 1'b0)
        dump_check('0, '0, 0, 1'b0);

        // T5: changes while disabled are ignored; first enabled cycle counts nothing
        enable = 1'b0;
        sig = 4'b0001; tick();
        sig = 4'b0011; tick();
        enable = 1'b1; sig = 4'b0111; tick();
        sig = 4'b0110; tick();
        sig = 4'b0111; tick();
        `CHK("t5_mask", covered_mask, 4'b0001)
        dump_check({2'd0, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd0, 2'd1}, 0, 1'b0);
        do_clear();

        // T6: clear beats simultaneous dump_req and a simultaneous edge
        sig = 4'b0110; tick();
        dump_req = 1'b1; clear = 1'b1; sig = 4'b0111; tick();
        dump_req = 1'b0; clear = 1'b0;
        `CHK("t6_no_dump_valid", out_valid, 1'b0)
        `CHK("t6_no_dump_busy", busy, 1'b0)
        `CHK("t6_mask", covered_mask, 4'h0)
        tick();
        `CHK("t6_still_idle", out_valid, 1'b0)
        dump_check('0, '0, 0, 1'b0);

        // Reset mid-dump
        sig = 4'b0110; tick();
        sig = 4'b0111; tick();
        `CHK("rstd_mask_pre", covered_mask, 4'b0001)
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        wait_valid("rstd_dump_start", 4);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_state("rstd_state");
        `CHK("rstd_valid", out_valid, 1'b0)
        `CHK("rstd_busy", busy, 1'b0)
        `CHK("rstd_index", out_index, 2'd0)
        `CHK("rstd_mask", covered_mask, 4'h0)
        `CHK("rstd_all", all_covered, 1'b0)
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        `CHK("rstd_no_records", out_valid, 1'b0)
        dump_check('0, '0, 0, 1'b0);

        if (n_fail != 0) begin
            $error("FAIL summary: %0d of %0d checks failed", n_fail, n_assert);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
